// File: rtl/fdtd_pkg.sv
// Shared types for the FDTD data-memory mover: command opcodes, sequencer states
// and the byte stride between consecutive field words.
package fdtd_pkg;

   typedef enum logic [2:0] {
      LD_HY  = 3'd0,
      LD_EZ  = 3'd1,
      LD_SRC = 3'd2,
      ST_HY  = 3'd3,
      ST_EZ  = 3'd4
   } fdtd_mover_op_e;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      CHECK    = 4'd1,
      LD_START = 4'd2,
      LD_GAP   = 4'd3,
      LD_XFER  = 4'd4,
      LD_END   = 4'd5,
      ST_SEL   = 4'd6,
      ST_RD    = 4'd7,
      ST_CAP   = 4'd8,
      ST_WR    = 4'd9,
      ST_END   = 4'd10,
      DONE     = 4'd11
   } fdtd_mover_state_e;

   localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/fdtd_mem_mover.sv
// Data-memory-side sequencer for the FDTD field buffer: streams Hy/Ez/src words from
// SRAM into the buffer's old RAMs (loads) and drains its new Hy/Ez RAMs back (stores).
module fdtd_mem_mover
   import fdtd_pkg::*;
#(
   parameter int FDTD_DATA_WIDTH   = 32,
   parameter int MEM_ADDR_WIDTH    = 32,
   parameter int FDTD_BUFFER_DEPTH = 64,
   parameter int LEN_WIDTH         = 16
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       cmd_valid_i,
   output logic                       cmd_ready_o,
   input  logic [2:0]                 cmd_op_i,
   input  logic [MEM_ADDR_WIDTH-1:0]  cmd_base_i,
   input  logic [LEN_WIDTH-1:0]       cmd_len_i,
   output logic                       done_o,
   output logic                       err_o,
   output logic                       mem_req_o,
   input  logic                       mem_gnt_i,
   output logic                       mem_we_o,
   output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
   output logic [FDTD_DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                       mem_rvalid_i,
   input  logic [FDTD_DATA_WIDTH-1:0] mem_rdata_i,
   output logic                       buffer_Hy_start_o,
   output logic                       buffer_Ez_start_o,
   output logic                       buffer_src_start_o,
   output logic                       buffer_Hy_end_o,
   output logic                       buffer_Ez_end_o,
   output logic                       buffer_src_end_o,
   output logic                       wrtvalid_Hy_old_o,
   output logic                       wrtvalid_Ez_old_o,
   output logic [FDTD_DATA_WIDTH-1:0] Hy_old_o,
   output logic [FDTD_DATA_WIDTH-1:0] Ez_old_o,
   output logic                       mem_rd_Hy_en_o,
   output logic                       mem_rd_Ez_en_o,
   output logic                       mem_rd_end_o,
   output logic                       wrtvalid_sgl_o,
   input  logic [FDTD_DATA_WIDTH-1:0] Hy_n_i,
   input  logic [FDTD_DATA_WIDTH-1:0] Ez_n_i
);

   localparam int CW = LEN_WIDTH + 1;
   localparam logic [CW-1:0]             MAX_LEN = CW'(FDTD_BUFFER_DEPTH);
   localparam logic [CW-1:0]             ONE     = CW'(1);
   localparam logic [MEM_ADDR_WIDTH-1:0] STRIDE  = MEM_ADDR_WIDTH'(WORD_STRIDE);

   fdtd_mover_state_e          state_q, state_d;
   fdtd_mover_op_e             op_q, op_d;
   logic [MEM_ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [LEN_WIDTH-1:0]       len_q, len_d;
   logic [CW-1:0]              issued_q, issued_d;
   logic [CW-1:0]              count_q, count_d;
   logic                       armed_q, armed_d;
   logic                       err_q, err_d;
   logic                       ldStrb_q, ldStrb_d;
   logic [FDTD_DATA_WIDTH-1:0] ldData_q, ldData_d;
   logic [FDTD_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [CW-1:0]              lenExt;
   logic                       readReq;

   assign lenExt = {1'b0, len_q};

   // Load words leave one cycle after rvalid from a register, so strobe timing is
   // independent of the SRAM's output path; LD_SRC shares the Ez old-RAM port.
   assign wrtvalid_Hy_old_o = ldStrb_q && (op_q == LD_HY);
   assign wrtvalid_Ez_old_o = ldStrb_q && (op_q != LD_HY);
   assign Hy_old_o          = ldData_q;
   assign Ez_old_o          = ldData_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         op_q     <= LD_HY;
         addr_q   <= '0;
         len_q    <= '0;
         issued_q <= '0;
         count_q  <= '0;
         armed_q  <= 1'b0;
         err_q    <= 1'b0;
         ldStrb_q <= 1'b0;
         ldData_q <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         issued_q <= issued_d;
         count_q  <= count_d;
         armed_q  <= armed_d;
         err_q    <= err_d;
         ldStrb_q <= ldStrb_d;
         ldData_q <= ldData_d;
         wdata_q  <= wdata_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      op_d               = op_q;
      addr_d             = addr_q;
      len_d              = len_q;
      issued_d           = issued_q;
      count_d            = count_q;
      armed_d            = armed_q;
      err_d              = err_q;
      ldStrb_d           = 1'b0;
      ldData_d           = ldData_q;
      wdata_d            = wdata_q;
      readReq            = 1'b0;
      cmd_ready_o        = 1'b0;
      done_o             = 1'b0;
      err_o              = 1'b0;
      mem_req_o          = 1'b0;
      mem_we_o           = 1'b0;
      mem_addr_o         = '0;
      mem_wdata_o        = '0;
      buffer_Hy_start_o  = 1'b0;
      buffer_Ez_start_o  = 1'b0;
      buffer_src_start_o = 1'b0;
      buffer_Hy_end_o    = 1'b0;
      buffer_Ez_end_o    = 1'b0;
      buffer_src_end_o   = 1'b0;
      mem_rd_Hy_en_o     = 1'b0;
      mem_rd_Ez_en_o     = 1'b0;
      mem_rd_end_o       = 1'b0;
      wrtvalid_sgl_o     = 1'b0;

      unique case (state_q)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               op_d     = fdtd_mover_op_e'(cmd_op_i);
               addr_d   = cmd_base_i;
               len_d    = cmd_len_i;
               issued_d = '0;
               count_d  = '0;
               err_d    = 1'b0;
               state_d  = CHECK;
            end
         end
         // Empty commands finish cleanly; oversize, unknown or unarmed stores are rejected.
         CHECK: begin
            if (len_q == '0) begin
               state_d = DONE;
            end else if (lenExt > MAX_LEN) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               case (op_q)
                  LD_HY, LD_EZ, LD_SRC: state_d = LD_START;
                  ST_HY, ST_EZ: begin
                     if (armed_q) begin
                        state_d = ST_SEL;
                     end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                     end
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = DONE;
                  end
               endcase
            end
         end
         LD_START: begin
            buffer_Hy_start_o  = (op_q == LD_HY);
            buffer_Ez_start_o  = (op_q == LD_EZ);
            buffer_src_start_o = (op_q == LD_SRC);
            state_d            = LD_GAP;
         end
         LD_GAP: begin
            state_d = LD_XFER;
         end
         // Reads are pipelined: keep requesting until all are issued, leave once all returned.
         LD_XFER: begin
            readReq    = (issued_q < lenExt);
            mem_req_o  = readReq;
            mem_addr_o = readReq ? addr_q : '0;
            if (readReq && mem_gnt_i) begin
               issued_d = issued_q + ONE;
               addr_d   = addr_q + STRIDE;
            end
            if (mem_rvalid_i) begin
               ldStrb_d = 1'b1;
               ldData_d = mem_rdata_i;
               count_d  = count_q + ONE;
            end
            if (count_q == lenExt) begin
               state_d = LD_END;
            end
         end
         LD_END: begin
            buffer_Hy_end_o  = (op_q == LD_HY);
            buffer_Ez_end_o  = (op_q == LD_EZ);
            buffer_src_end_o = (op_q == LD_SRC);
            if (op_q != LD_HY) begin
               armed_d = 1'b1;
            end
            state_d = DONE;
         end
         ST_SEL: begin
            mem_rd_Hy_en_o = (op_q == ST_HY);
            mem_rd_Ez_en_o = (op_q == ST_EZ);
            state_d        = ST_RD;
         end
         ST_RD: begin
            wrtvalid_sgl_o = 1'b1;
            state_d        = ST_CAP;
         end
         ST_CAP: begin
            wdata_d = (op_q == ST_HY) ? Hy_n_i : Ez_n_i;
            state_d = ST_WR;
         end
         ST_WR: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            if (mem_gnt_i) begin
               addr_d  = addr_q + STRIDE;
               count_d = count_q + ONE;
               state_d = ((count_q + ONE) == lenExt) ? ST_END : ST_RD;
            end
         end
         ST_END: begin
            mem_rd_end_o = 1'b1;
            armed_d      = 1'b0;
            state_d      = DONE;
         end
         DONE: begin
            done_o  = 1'b1;
            err_o   = err_q;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fdtd_mem_mover.sv
// Directed self-checking bench for fdtd_mem_mover with a reactive SRAM model (grant
// stalls, 1-cycle read latency) and a field-buffer model answering store strobes.
module tb_fdtd_mem_mover;
   import fdtd_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [2:0]  cmd_op_i;
   logic [31:0] cmd_base_i;
   logic [15:0] cmd_len_i;
   logic        done_o, err_o;
   logic        mem_req_o, mem_we_o;
   logic        mem_gnt_i = 1'b0;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        buffer_Hy_start_o, buffer_Ez_start_o, buffer_src_start_o;
   logic        buffer_Hy_end_o, buffer_Ez_end_o, buffer_src_end_o;
   logic        wrtvalid_Hy_old_o, wrtvalid_Ez_old_o;
   logic [31:0] Hy_old_o, Ez_old_o;
   logic        mem_rd_Hy_en_o, mem_rd_Ez_en_o, mem_rd_end_o, wrtvalid_sgl_o;
   logic [31:0] Hy_n_i = '0;
   logic [31:0] Ez_n_i = '0;

   int checks = 0;
   int errors = 0;

   fdtd_mem_mover #(
      .FDTD_DATA_WIDTH(32), .MEM_ADDR_WIDTH(32), .FDTD_BUFFER_DEPTH(64), .LEN_WIDTH(16)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_base_i(cmd_base_i), .cmd_len_i(cmd_len_i), .done_o(done_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .buffer_Hy_start_o(buffer_Hy_start_o), .buffer_Ez_start_o(buffer_Ez_start_o),
      .buffer_src_start_o(buffer_src_start_o), .buffer_Hy_end_o(buffer_Hy_end_o),
      .buffer_Ez_end_o(buffer_Ez_end_o), .buffer_src_end_o(buffer_src_end_o),
      .wrtvalid_Hy_old_o(wrtvalid_Hy_old_o), .wrtvalid_Ez_old_o(wrtvalid_Ez_old_o),
      .Hy_old_o(Hy_old_o), .Ez_old_o(Ez_old_o),
      .mem_rd_Hy_en_o(mem_rd_Hy_en_o), .mem_rd_Ez_en_o(mem_rd_Ez_en_o),
      .mem_rd_end_o(mem_rd_end_o), .wrtvalid_sgl_o(wrtvalid_sgl_o),
      .Hy_n_i(Hy_n_i), .Ez_n_i(Ez_n_i)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a << 4) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] hyVal(input int i);
      return 32'h1111_0000 + 32'(i);
   endfunction

   function automatic logic [31:0] ezVal(input int i);
      return 32'h2222_0000 + 32'(i);
   endfunction

   // Observation counters and model state, all updated on the falling edge.
   int cyc = 0;
   int startHy, startEz, startSrc, endHy, endEz, endSrc;
   int hyStrb, ezStrb, rdHyEn, rdEzEn, rdEnd, sglCnt, reqCycles, stallCycles;
   int startCyc, firstStrb, lastStrb, endCyc;
   int grantCnt, stallAt, stallLeft, wrCnt, sglIdx;
   logic [31:0] strbData [0:127];
   logic [31:0] wrAddr [0:63];
   logic [31:0] wrData [0:63];
   logic [31:0] stallAddr, stallData, pendData;
   logic        pendRead = 1'b0;
   logic        sglPending = 1'b0;

   always @(negedge CLK) begin
      cyc++;
      if (buffer_Hy_start_o || buffer_Ez_start_o || buffer_src_start_o) startCyc = cyc;
      if (buffer_Hy_start_o) startHy++;
      if (buffer_Ez_start_o) startEz++;
      if (buffer_src_start_o) startSrc++;
      if (buffer_Hy_end_o || buffer_Ez_end_o || buffer_src_end_o) endCyc = cyc;
      if (buffer_Hy_end_o) endHy++;
      if (buffer_Ez_end_o) endEz++;
      if (buffer_src_end_o) endSrc++;
      if (wrtvalid_Hy_old_o || wrtvalid_Ez_old_o) begin
         if (firstStrb < 0) firstStrb = cyc;
         lastStrb = cyc;
         strbData[(hyStrb + ezStrb) % 128] = wrtvalid_Hy_old_o ? Hy_old_o : Ez_old_o;
      end
      if (wrtvalid_Hy_old_o) hyStrb++;
      if (wrtvalid_Ez_old_o) ezStrb++;
      if (mem_rd_Hy_en_o) rdHyEn++;
      if (mem_rd_Ez_en_o) rdEzEn++;
      if (mem_rd_end_o) rdEnd++;

      mem_rvalid_i = pendRead;
      mem_rdata_i  = pendRead ? pendData : 32'hBAD0_BAD0;
      if (mem_req_o) reqCycles++;
      if (mem_req_o && stallLeft > 0 && grantCnt == stallAt) begin
         mem_gnt_i = 1'b0;
         stallLeft--;
         stallCycles++;
         stallAddr = mem_addr_o;
         stallData = mem_wdata_o;
      end else begin
         mem_gnt_i = 1'b1;
      end
      if (mem_req_o && mem_gnt_i) begin
         grantCnt++;
         if (mem_we_o) begin
            wrAddr[wrCnt % 64] = mem_addr_o;
            wrData[wrCnt % 64] = mem_wdata_o;
            wrCnt++;
         end
      end
      pendRead = mem_req_o && mem_gnt_i && !mem_we_o;
      pendData = memWord(mem_addr_o);

      Hy_n_i = sglPending ? hyVal(sglIdx) : 32'hDEAD_BEEF;
      Ez_n_i = sglPending ? ezVal(sglIdx) : 32'hDEAD_BEEF;
      if (sglPending) sglIdx++;
      sglPending = wrtvalid_sgl_o;
      if (wrtvalid_sgl_o) sglCnt++;
   end

   task automatic clearCounters();
      startHy = 0; startEz = 0; startSrc = 0; endHy = 0; endEz = 0; endSrc = 0;
      hyStrb = 0; ezStrb = 0; rdHyEn = 0; rdEzEn = 0; rdEnd = 0; sglCnt = 0;
      reqCycles = 0; stallCycles = 0; startCyc = -1; firstStrb = -1; lastStrb = -1;
      endCyc = -1; grantCnt = 0; stallAt = -1; stallLeft = 0; wrCnt = 0; sglIdx = 0;
      stallAddr = '0; stallData = '0;
   endtask

   // Issues one command, waits (bounded) for done_o, returns err_o seen with it.
   task automatic sendCmd(input fdtd_mover_op_e op, input logic [31:0] base,
                          input logic [15:0] len, output logic err);
      bit seen = 0;
      err = 1'bx;
      @(negedge CLK);
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ready_before_cmd got %b exp 1", cmd_ready_o);
      end
      cmd_valid_i = 1'b1;
      cmd_op_i    = op;
      cmd_base_i  = base;
      cmd_len_i   = len;
      @(posedge CLK);
      #1 cmd_valid_i = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (done_o === 1'b1) begin
            seen = 1;
            err  = err_o;
            break;
         end
         @(posedge CLK);
         #1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("[TB] FAIL done_timeout op=%0d got no done exp done within 400 cycles", op);
      end
      repeat (2) @(negedge CLK);
      #2;
   endtask

   task automatic test_reset();
      logic [18:0] outs;
      RST_N = 1'b0;
      cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_base_i = '0; cmd_len_i = '0;
      repeat (3) @(negedge CLK);
      outs = {done_o, err_o, mem_req_o, mem_we_o, buffer_Hy_start_o, buffer_Ez_start_o,
              buffer_src_start_o, buffer_Hy_end_o, buffer_Ez_end_o, buffer_src_end_o,
              wrtvalid_Hy_old_o, wrtvalid_Ez_old_o, mem_rd_Hy_en_o, mem_rd_Ez_en_o,
              mem_rd_end_o, wrtvalid_sgl_o, |mem_addr_o, |mem_wdata_o, |Hy_old_o};
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_ready got %b exp 1", cmd_ready_o);
      end
      checks++;
      if (outs !== '0) begin
         errors++; $display("[TB] FAIL reset_outputs got %b exp 0", outs);
      end
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);
      #2 clearCounters();
   endtask

   task automatic test_load_hy();
      logic err;
      clearCounters();
      sendCmd(LD_HY, 32'h100, 16'd4, err);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL ldhy_err got %b exp 0", err); end
      checks++; if (startHy !== 1 || startEz !== 0 || startSrc !== 0) begin errors++;
         $display("[TB] FAIL ldhy_start got hy=%0d ez=%0d src=%0d exp 1/0/0", startHy, startEz, startSrc); end
      checks++; if (hyStrb !== 4 || ezStrb !== 0) begin errors++;
         $display("[TB] FAIL ldhy_strobes got hy=%0d ez=%0d exp 4/0", hyStrb, ezStrb); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (strbData[i] !== memWord(32'h100 + 32'(4 * i))) begin errors++;
            $display("[TB] FAIL ldhy_data%0d got %h exp %h", i, strbData[i], memWord(32'h100 + 32'(4 * i))); end
      end
      checks++; if (lastStrb - firstStrb !== 3) begin errors++;
         $display("[TB] FAIL ldhy_back_to_back got span %0d exp 3", lastStrb - firstStrb); end
      checks++; if ((firstStrb - startCyc >= 2) !== 1'b1) begin errors++;
         $display("[TB] FAIL ldhy_gap got %0d exp >=2", firstStrb - startCyc); end
      checks++; if (endHy !== 1 || endCyc - lastStrb !== 1) begin errors++;
         $display("[TB] FAIL ldhy_end got count=%0d delay=%0d exp 1/1", endHy, endCyc - lastStrb); end
      checks++; if (grantCnt !== 4) begin errors++;
         $display("[TB] FAIL ldhy_grants got %0d exp 4", grantCnt); end
   endtask

   task automatic test_load_ez_stall();
      logic err;
      clearCounters();
      stallAt = 1; stallLeft = 2;
      sendCmd(LD_EZ, 32'h200, 16'd3, err);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL ldez_err got %b exp 0", err); end
      checks++; if (stallCycles !== 2 || stallAddr !== 32'h204) begin errors++;
         $display("[TB] FAIL ldez_stall_addr got n=%0d addr=%h exp 2/00000204", stallCycles, stallAddr); end
      checks++; if (ezStrb !== 3 || hyStrb !== 0) begin errors++;
         $display("[TB] FAIL ldez_strobes got ez=%0d hy=%0d exp 3/0", ezStrb, hyStrb); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (strbData[i] !== memWord(32'h200 + 32'(4 * i))) begin errors++;
            $display("[TB] FAIL ldez_data%0d got %h exp %h", i, strbData[i], memWord(32'h200 + 32'(4 * i))); end
      end
      checks++; if (startEz !== 1 || endEz !== 1 || endHy !== 0) begin errors++;
         $display("[TB] FAIL ldez_pulses got start=%0d end=%0d endHy=%0d exp 1/1/0", startEz, endEz, endHy); end
   endtask

   task automatic test_store_ez();
      logic err;
      clearCounters();
      stallAt = 1; stallLeft = 1;
      sendCmd(ST_EZ, 32'h300, 16'd3, err);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL stez_err got %b exp 0", err); end
      checks++; if (rdEzEn !== 1 || rdHyEn !== 0) begin errors++;
         $display("[TB] FAIL stez_select got ez=%0d hy=%0d exp 1/0", rdEzEn, rdHyEn); end
      checks++; if (sglCnt !== 3 || wrCnt !== 3) begin errors++;
         $display("[TB] FAIL stez_counts got sgl=%0d wr=%0d exp 3/3", sglCnt, wrCnt); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wrAddr[i] !== 32'h300 + 32'(4 * i) || wrData[i] !== ezVal(i)) begin errors++;
            $display("[TB] FAIL stez_write%0d got %h@%h exp %h@%h", i, wrData[i], wrAddr[i],
                     ezVal(i), 32'h300 + 32'(4 * i)); end
      end
      checks++; if (stallAddr !== 32'h304 || stallData !== ezVal(1)) begin errors++;
         $display("[TB] FAIL stez_stall_hold got %h@%h exp %h@00000304", stallData, stallAddr, ezVal(1)); end
      checks++; if (rdEnd !== 1) begin errors++; $display("[TB] FAIL stez_rd_end got %0d exp 1", rdEnd); end
   endtask

   task automatic test_rejects();
      logic err;
      clearCounters();
      sendCmd(ST_HY, 32'h300, 16'd2, err);
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL unarmed_err got %b exp 1", err); end
      checks++; if (reqCycles !== 0 || sglCnt !== 0 || rdHyEn !== 0) begin errors++;
         $display("[TB] FAIL unarmed_traffic got req=%0d sgl=%0d sel=%0d exp 0/0/0", reqCycles, sglCnt, rdHyEn); end
      clearCounters();
      sendCmd(LD_HY, 32'h100, 16'd0, err);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL len0_err got %b exp 0", err); end
      checks++; if (reqCycles !== 0 || startHy !== 0) begin errors++;
         $display("[TB] FAIL len0_traffic got req=%0d start=%0d exp 0/0", reqCycles, startHy); end
      clearCounters();
      sendCmd(LD_SRC, 32'h100, 16'd65, err);
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL len65_err got %b exp 1", err); end
      checks++; if (reqCycles !== 0 || startSrc !== 0) begin errors++;
         $display("[TB] FAIL len65_traffic got req=%0d start=%0d exp 0/0", reqCycles, startSrc); end
   endtask

   task automatic test_load_src_store_hy();
      logic err;
      int bad = 0;
      clearCounters();
      sendCmd(LD_SRC, 32'h1000, 16'd64, err);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL ldsrc_err got %b exp 0", err); end
      checks++; if (ezStrb !== 64 || hyStrb !== 0 || lastStrb - firstStrb !== 63) begin errors++;
         $display("[TB] FAIL ldsrc_strobes got ez=%0d hy=%0d span=%0d exp 64/0/63", ezStrb, hyStrb, lastStrb - firstStrb); end
      for (int i = 0; i < 64; i++) if (strbData[i] !== memWord(32'h1000 + 32'(4 * i))) bad++;
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL ldsrc_data got %0d bad words exp 0", bad); end
      checks++; if (startSrc !== 1 || endSrc !== 1 || endEz !== 0) begin errors++;
         $display("[TB] FAIL ldsrc_pulses got start=%0d end=%0d endEz=%0d exp 1/1/0", startSrc, endSrc, endEz); end
      clearCounters();
      sendCmd(ST_HY, 32'h2000, 16'd2, err);
      checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL sthy_err got %b exp 0", err); end
      checks++; if (rdHyEn !== 1 || rdEzEn !== 0 || wrCnt !== 2) begin errors++;
         $display("[TB] FAIL sthy_counts got hy=%0d ez=%0d wr=%0d exp 1/0/2", rdHyEn, rdEzEn, wrCnt); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (wrAddr[i] !== 32'h2000 + 32'(4 * i) || wrData[i] !== hyVal(i)) begin errors++;
            $display("[TB] FAIL sthy_write%0d got %h@%h exp %h@%h", i, wrData[i], wrAddr[i],
                     hyVal(i), 32'h2000 + 32'(4 * i)); end
      end
   endtask

   task automatic test_reset_mid();
      logic err;
      logic [3:0] outs;
      sendCmd(LD_EZ, 32'h40, 16'd1, err);
      clearCounters();
      @(negedge CLK);
      cmd_valid_i = 1'b1; cmd_op_i = LD_HY; cmd_base_i = 32'h400; cmd_len_i = 16'd8;
      @(posedge CLK);
      #1 cmd_valid_i = 1'b0;
      for (int i = 0; i < 100 && hyStrb < 4; i++) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      outs = {mem_req_o, wrtvalid_Hy_old_o, buffer_Hy_end_o, done_o};
      checks++; if (cmd_ready_o !== 1'b1 || outs !== '0) begin errors++;
         $display("[TB] FAIL midreset_outputs got ready=%b outs=%b exp 1/0000", cmd_ready_o, outs); end
      checks++; if (hyStrb < 4 || hyStrb >= 8) begin errors++;
         $display("[TB] FAIL midreset_timing got %0d strobes before reset exp 4..7", hyStrb); end
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      #2;
      checks++; if (endHy !== 0) begin errors++; $display("[TB] FAIL midreset_no_end got %0d exp 0", endHy); end
      sendCmd(ST_EZ, 32'h500, 16'd1, err);
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL midreset_disarm got %b exp 1", err); end
      clearCounters();
      sendCmd(LD_HY, 32'h600, 16'd4, err);
      checks++; if (err !== 1'b0 || hyStrb !== 4 || endHy !== 1) begin errors++;
         $display("[TB] FAIL postreset_load got err=%b n=%0d end=%0d exp 0/4/1", err, hyStrb, endHy); end
      checks++; if (strbData[0] !== memWord(32'h600) || strbData[3] !== memWord(32'h60C)) begin errors++;
         $display("[TB] FAIL postreset_data got %h,%h exp %h,%h", strbData[0], strbData[3],
                  memWord(32'h600), memWord(32'h60C)); end
   endtask

   initial begin
      clearCounters();
      test_reset();
      test_load_hy();
      test_load_ez_stall();
      test_store_ez();
      test_rejects();
      test_load_src_store_hy();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
